// File: rtl/rmw_tbl.sv
// Fixed-latency table model: tagged reads return entry data LAT cycles after accept, with write forwarding into in-flight reads.
// Latency: LAT cycles read-to-response; writes land at the end of their accept cycle.
// Backpressure: none on responses; rd_rdy (shared by reads and writes) stays low during reset and the zeroing sweep.
module rmw_tbl #(
    parameter int DEPTH = 256,
    parameter int LAT   = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_vld,
    input  logic [15:0]      rd_id,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_rdy,
    input  logic             wr_vld,
    input  logic [15:0]      wr_id,
    input  logic [31:0]      wr_dat,
    output logic             rsp_vld,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_dat,
    output logic             busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int NS = LAT - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     init_cnt;
    logic [31:0]       mem [DEPTH];

    logic              rd_acc, wr_acc;
    logic [IW-1:0]     rd_idx, wr_idx;
    logic [31:0]       rd_dat_fwd;

    logic [NS-1:0]     s_vld;
    logic [TAG_W-1:0]  s_tag [NS];
    logic [IW-1:0]     s_idx [NS];
    logic [31:0]       s_dat [NS];
    logic [31:0]       s_dat_fwd [NS];

    // Aliasing is intended: only the low index bits select an entry.
    logic              unused_id_bits;
    assign unused_id_bits = ^{rd_id[15:IW], wr_id[15:IW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_cnt == IW'(DEPTH - 1)) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        rd_rdy = (state == ST_RUN);
        busy   = (state != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 init_cnt <= '0;
        else if (state == ST_INIT)  init_cnt <= init_cnt + 1'b1;
    end

    assign rd_acc = rd_vld & rd_rdy;
    assign wr_acc = wr_vld & rd_rdy;
    assign rd_idx = rd_id[IW-1:0];
    assign wr_idx = wr_id[IW-1:0];

    always_ff @(posedge clk) begin
        if (state == ST_INIT) mem[init_cnt] <= '0;
        else if (wr_acc)      mem[wr_idx]   <= wr_dat;
    end

    // Write-first: a same-cycle write to the read index is what the read captures.
    assign rd_dat_fwd = (wr_acc && (wr_idx == rd_idx)) ? wr_dat : mem[rd_idx];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_dat_fwd[i] = (wr_acc && s_vld[i] && (s_idx[i] == wr_idx)) ? wr_dat : s_dat[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld   <= '0;
            for (int i = 0; i < NS; i++) begin
                s_tag[i] <= '0;
                s_idx[i] <= '0;
                s_dat[i] <= '0;
            end
            rsp_vld <= 1'b0;
            rsp_tag <= '0;
            rsp_dat <= '0;
        end else begin
            s_vld[0] <= rd_acc;
            s_tag[0] <= rd_tag;
            s_idx[0] <= rd_idx;
            s_dat[0] <= rd_dat_fwd;
            for (int i = 1; i < NS; i++) begin
                s_vld[i] <= s_vld[i-1];
                s_tag[i] <= s_tag[i-1];
                s_idx[i] <= s_idx[i-1];
                s_dat[i] <= s_dat_fwd[i-1];
            end
            // Last forwarding point: a write in the response cycle itself is not seen.
            rsp_vld <= s_vld[NS-1];
            if (s_vld[NS-1]) begin
                rsp_tag <= s_tag[NS-1];
                rsp_dat <= s_dat_fwd[NS-1];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(rd_vld));
            assert (!$isunknown(wr_vld));
            if (rd_vld && rd_rdy) begin
                for (int i = 0; i < NS; i++) begin
                    assert (!(s_vld[i] && (s_tag[i] == rd_tag)));
                end
            end
        end
    end

endmodule

// File: tb/tb_rmw_tbl.sv
// Directed bench for rmw_tbl: scoreboard queue of expected responses, checked on the falling edge.
module tb_rmw_tbl;

    localparam int DEPTH = 256;
    localparam int LAT   = 8;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             rd_vld;
    logic [15:0]      rd_id;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_rdy;
    logic             wr_vld;
    logic [15:0]      wr_id;
    logic [31:0]      wr_dat;
    logic             rsp_vld;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_dat;
    logic             busy;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      dat;
        int               cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [DEPTH];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    rmw_tbl #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_vld  (rd_vld),
        .rd_id   (rd_id),
        .rd_tag  (rd_tag),
        .rd_rdy  (rd_rdy),
        .wr_vld  (wr_vld),
        .wr_id   (wr_id),
        .wr_dat  (wr_dat),
        .rsp_vld (rsp_vld),
        .rsp_tag (rsp_tag),
        .rsp_dat (rsp_dat),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Response monitor: every expected response must arrive in its exact cycle, nothing else may.
    always @(negedge clk) begin
        logic expect_rsp;
        exp_t e;
        expect_rsp = (q.size() > 0) && (q[0].cyc == cyc);
        if (expect_rsp || rsp_vld !== 1'b0) begin
            chk("rsp_vld", {31'd0, rsp_vld}, {31'd0, expect_rsp});
            if (expect_rsp) begin
                e = q.pop_front();
                chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
                chk("rsp_dat", rsp_dat, e.dat);
            end
        end
    end

    // One cycle of stimulus, driven just after a falling edge.
    task automatic issue(input logic rv, input logic [15:0] rid, input logic [TAG_W-1:0] tg,
                         input logic [31:0] exp_dat,
                         input logic wv, input logic [15:0] wid, input logic [31:0] wd);
        exp_t e;
        rd_vld = rv;  rd_id = rid;  rd_tag = tg;
        wr_vld = wv;  wr_id = wid;  wr_dat = wd;
        if (wv) mdl[wid[7:0]] = wd;
        if (rv) begin
            e.tag = tg;
            e.dat = exp_dat;
            e.cyc = cyc + LAT;
            q.push_back(e);
        end
        @(negedge clk);
        rd_vld = 1'b0;
        wr_vld = 1'b0;
    endtask

    task automatic rd(input logic [15:0] rid, input logic [TAG_W-1:0] tg, input logic [31:0] exp_dat);
        issue(1'b1, rid, tg, exp_dat, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic wr(input logic [15:0] wid, input logic [31:0] wd);
        issue(1'b0, 16'h0, '0, 32'h0, 1'b1, wid, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the falling edge where rst_n has just been released.
    task automatic wait_init(input string pfx);
        repeat (DEPTH - 1) @(negedge clk);
        chk({pfx, "_rdy_last_init"},  {31'd0, rd_rdy}, 32'd0);
        chk({pfx, "_busy_last_init"}, {31'd0, busy},   32'd1);
        @(negedge clk);
        chk({pfx, "_rdy_run"},  {31'd0, rd_rdy}, 32'd1);
        chk({pfx, "_busy_run"}, {31'd0, busy},   32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rd_vld = 1'b0;  rd_id = '0;  rd_tag = '0;
        wr_vld = 1'b0;  wr_id = '0;  wr_dat = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        chk("rst_rsp_dat", rsp_dat,          32'd0);
        chk("rst_rd_rdy",  {31'd0, rd_rdy},  32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd1);

        rst_n = 1'b1;
        wait_init("init1");
        rd(16'h0005, 4'd0, 32'h0);

        wr(16'h0010, 32'hDEAD_BEEF);
        rd(16'h0010, 4'd3, mdl[8'h10]);

        // Read in flight while writes land at t, t+4 and t+8 (the response cycle).
        issue(1'b1, 16'h0020, 4'd1, 32'h0000_0022, 1'b1, 16'h0020, 32'h0000_0011);
        idle(3);
        wr(16'h0020, 32'h0000_0022);
        idle(3);
        wr(16'h0020, 32'h0000_0033);
        rd(16'h0020, 4'd2, 32'h0000_0033);
        idle(LAT + 2);

        for (int i = 0; i < 16; i++) wr(16'h0040 + 16'(i), 32'h1000_0000 + 32'(i) * 32'h111);
        for (int i = 0; i < 16; i++) rd(16'h0040 + 16'(i), 4'(i), mdl[8'h40 + 8'(i)]);
        idle(LAT + 2);

        wr(16'h0107, 32'h0000_00A5);
        rd(16'h0007, 4'd5, 32'h0000_00A5);
        idle(LAT + 2);

        rd(16'h0010, 4'd8,  mdl[8'h10]);
        rd(16'h0020, 4'd9,  mdl[8'h20]);
        rd(16'h0040, 4'd10, mdl[8'h40]);
        rd(16'h0007, 4'd11, mdl[8'h07]);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        #1;
        chk("midrst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("midrst_busy",    {31'd0, busy},    32'd1);
        chk("midrst_rd_rdy",  {31'd0, rd_rdy},  32'd0);
        idle(LAT + 4);
        rst_n = 1'b1;
        wait_init("init2");
        rd(16'h0010, 4'd0, 32'h0);
        rd(16'h0107, 4'd1, 32'h0);
        rd(16'h0020, 4'd2, 32'h0);
        idle(LAT + 4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmw_tbl.md
# rmw_tbl

Long-latency table model sitting directly downstream of the RMW command engine. It accepts tagged read lookups and returns the entry data exactly LAT cycles later on a fixed-latency pipeline. It also accepts write-backs of modified words, and every in-flight read observes those writes, so the engine never sees a stale value. After reset, an internal sweep zero-initialises the table before any traffic is accepted.

## Interface
Parameters:
- DEPTH, 256 — table entries; power of two, 2..4096; index is id[$clog2(DEPTH)-1:0], upper id bits ignored.
- LAT, 8 — read latency in cycles; 2..32.
- TAG_W, 4 — width of the lookup tag, equal to the package TAG_W (IN_FLIGHT_N = 16).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_vld  in  1  read request valid.
- rd_id  in  16  read id (id_t).
- rd_tag  in  TAG_W  tag echoed with the response.
- rd_rdy  out  1  table accepts reads and writes; low during reset and INIT.
- wr_vld  in  1  write-back valid; accepted only when rd_rdy=1.
- wr_id  in  16  write id (id_t).
- wr_dat  in  32  write data (word_t).
- rsp_vld  out  1  response valid; one-cycle pulse, no backpressure.
- rsp_tag  out  TAG_W  tag of the response.
- rsp_dat  out  32  entry data (word_t).
- busy  out  1  high while in reset or INIT.

## Operation
- FSM states: INIT and RUN.
  - rst_n low: asynchronously enter INIT, set init counter to 0, and clear all pipeline valids.
  - INIT: write 0 to entry[counter] and increment once per cycle. When counter = DEPTH-1, write that entry and move to RUN on the next edge. INIT takes exactly DEPTH cycles.
  - RUN: stays in RUN until reset.
- rd_rdy = (state == RUN). busy = !rd_rdy.
- Requests with rd_vld or wr_vld while rd_rdy=0 are dropped, with no side effects.
- Read accepted (rd_vld & rd_rdy) in cycle t:
  - Stage 0 captures tag, index and entry[index].
  - Accepted reads advance one stage per cycle through LAT stages. There are no stalls and no bubbles removed.
  - A read can be accepted every cycle, so LAT reads can be in flight at once.
- Write accepted in cycle w: entry[wr_idx] <= wr_dat at the end of cycle w.
- Forwarding: in every cycle, each valid in-flight stage whose index equals wr_idx of an accepted write replaces its data with wr_dat.
  - The response therefore reflects every write accepted in cycles t..t+LAT-1.
  - Same-cycle read and write to the same index: write-first, so the read returns wr_dat.
  - A write in cycle t+LAT, the response cycle, is not reflected.
- Arithmetic: indices are truncated from 16 bits. Different ids with equal low bits alias to one entry (by design).
- Simulation-only assertions:
  - rd_tag must not equal any tag currently in flight.
  - rd_vld/wr_vld must not be X out of reset.

## Timing
- Reset values: rsp_vld=0, rsp_tag=0, rsp_dat=0, rd_rdy=0, busy=1. The table contents are not reset; INIT clears them.
- First accept is possible at the first edge after DEPTH cycles of INIT, counted from the first clk edge with rst_n high.
- Read latency: accepted at edge t, rsp_vld is high for cycle t+LAT, registered outputs.
- Throughput: 1 read + 1 write per cycle.
- Reset mid-operation:
  - rsp_vld falls immediately (asynchronous) and in-flight reads are discarded with no response.
  - The table re-initialises to zero and the consumer must reissue.
- Back-to-back writes to the same index during a read's flight: the last accepted write wins in the response.

## Test plan
- Reset release with DEPTH=256: busy=1 and rd_rdy=0 for 256 cycles, then rd_rdy=1. An immediate read of id 0x0005 returns rsp_dat=0 exactly LAT=8 cycles later with the matching tag.
- Write id 0x0010 = 0xDEADBEEF, then read 0x0010 with tag 3 the next cycle → rsp_tag=3, rsp_dat=0xDEADBEEF at +8.
- Read id 0x0020 with tag 1 at t; writes to 0x0020 of 0x11 at t, 0x22 at t+4, 0x33 at t+8 → response at t+8 carries 0x22, and a later read returns 0x33.
- 16 back-to-back reads with tags 0..15 to distinct ids → 16 consecutive rsp_vld cycles, in order, with correct data.
- Alias: write id 0x0107 = 0xA5, read id 0x0007 → 0xA5.
- Assert rst_n low at t+3 with 4 reads in flight → rsp_vld=0 with no responses, busy=1, a full re-INIT, and prior data reads back as 0.
